// File: rtl/pwm_seq_pkg.sv
// Shared types and default constants for the PWM speed sequencer.
// Imported by the interface, the debouncer and the top level.
package pwm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    HOLD,
    STOP
  } state_t;

  localparam int DEF_SPEED_W    = 3;
  localparam int DEF_SPEED_MAX  = 7;
  localparam int DEF_DEBOUNCE   = 16;
  localparam int DEF_RAMP_TICKS = 1024;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_speed_sequencer_if.sv
// Sequencer-to-PWM-generator bundle: speed code, enable and status.
// master drives it, slave (the generator / observers) reads it.
interface pwm_speed_sequencer_if
  import pwm_seq_pkg::*;
#(
  parameter int SPEED_W = DEF_SPEED_W
);

  logic [SPEED_W-1:0] speed;
  logic               enable;
  logic [SPEED_W-1:0] target;
  logic               busy;

  modport master (
    output speed,
    output enable,
    output target,
    output busy
  );

  modport slave (
    input speed,
    input enable,
    input target,
    input busy
  );

endinterface

// File: rtl/pwm_speed_sequencer_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, mismatch-count
// debounce and a registered one-cycle press pulse.
module btn_debounce
  import pwm_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] C_LAST =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  logic          sync_a;
  logic          sync_b;
  logic          stable;
  logic          stable_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a   <= 1'b0;
      sync_b   <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync_a   <= raw;
      sync_b   <= sync_a;
      stable_q <= stable;
      press    <= stable & ~stable_q;
      if (sync_b != stable) begin
        if (cnt == C_LAST) begin
          stable <= sync_b;
          cnt    <= '0;
        end else begin
          cnt <= cnt + C_ONE;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/pwm_speed_sequencer.sv
// Button-driven soft-start/soft-stop speed sequencer feeding
// the PWM generator's speed code and enable.
module pwm_speed_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int RAMP_TICKS      = DEF_RAMP_TICKS,
  parameter int SPEED_W         = DEF_SPEED_W,
  parameter int SPEED_MAX       = DEF_SPEED_MAX
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_up,
  input  logic                  btn_dn,
  input  logic                  btn_run,
  input  logic                  estop,
  pwm_speed_sequencer_if.master pwm
);

  localparam int TW = cnt_width(RAMP_TICKS);
  localparam logic [TW-1:0] T_LAST = TW'(RAMP_TICKS - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [SPEED_W-1:0] S_MAX = SPEED_W'(SPEED_MAX);
  localparam logic [SPEED_W-1:0] S_ONE = SPEED_W'(1);

  logic               up_p;
  logic               dn_p;
  logic               run_p;
  logic [1:0]         es_sync;
  logic               estop_s;
  logic               run_req;
  logic [SPEED_W-1:0] target_q;
  logic [SPEED_W-1:0] speed_q;
  logic [SPEED_W-1:0] speed_n;
  logic [TW-1:0]      tick_cnt;
  logic               tick;
  logic               busy;
  logic               enter;
  logic               inc;
  logic               dec;
  state_t             state;
  state_t             state_n;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_up (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_up),
    .press(up_p)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_dn (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_dn),
    .press(dn_p)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_run (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_run),
    .press(run_p)
  );

  // estop must act fast, so it is synchronised but not debounced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      es_sync <= 2'b00;
    end else begin
      es_sync <= {es_sync[0], estop};
    end
  end

  assign estop_s = es_sync[1];

  assign inc = up_p & ~dn_p & (target_q < S_MAX);
  assign dec = dn_p & ~up_p & (target_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= '0;
    end else if (!estop_s) begin
      if (inc) begin
        target_q <= target_q + S_ONE;
      end else if (dec) begin
        target_q <= target_q - S_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_req <= 1'b0;
    end else if (estop_s) begin
      run_req <= 1'b0;
    end else if (run_p) begin
      run_req <= ~run_req;
    end
  end

  assign busy  = (state == RAMP) || (state == STOP);
  assign tick  = busy && (tick_cnt == T_LAST);
  assign enter = (state_n != state) &&
                 ((state_n == RAMP) || (state_n == STOP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (enter) begin
      tick_cnt <= '0;
    end else if (busy) begin
      tick_cnt <= tick ? '0 : tick_cnt + T_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      speed_q <= '0;
    end else begin
      state   <= state_n;
      speed_q <= speed_n;
    end
  end

  // Target never exceeds SPEED_MAX, so stepping toward it
  // cannot wrap in either direction.
  always_comb begin
    state_n = state;
    speed_n = speed_q;
    if (estop_s) begin
      state_n = IDLE;
      speed_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          speed_n = '0;
          if (run_req) begin
            state_n = RAMP;
          end
        end
        RAMP: begin
          if (!run_req) begin
            state_n = STOP;
          end else if (speed_q == target_q) begin
            state_n = HOLD;
          end else if (tick) begin
            if (speed_q < target_q) begin
              speed_n = speed_q + S_ONE;
            end else begin
              speed_n = speed_q - S_ONE;
            end
          end
        end
        HOLD: begin
          if (!run_req) begin
            state_n = STOP;
          end else if (target_q != speed_q) begin
            state_n = RAMP;
          end
        end
        STOP: begin
          if (run_req) begin
            state_n = RAMP;
          end else if (speed_q == '0) begin
            state_n = IDLE;
          end else if (tick) begin
            speed_n = speed_q - S_ONE;
          end
        end
        default: begin
          state_n = IDLE;
          speed_n = '0;
        end
      endcase
    end
  end

  assign pwm.speed  = speed_q;
  assign pwm.enable = (state != IDLE);
  assign pwm.target = target_q;
  assign pwm.busy   = busy;

endmodule
